// File: rtl/mapper_v1_0.sv
`default_nettype none
// ============================================================================
//  Module      : mapper_v1_0
//  Description : Transmit subcarrier mapper. Places 16-bit I/Q payload samples
//                onto the data bins of a 1024-bin OFDM symbol, inserts zeros
//                on DC, guard band and top bin, and widens each component
//                into the 32-bit lane format used by the receive demapper.
//  Revision    : 1.0 - initial release
// ============================================================================
module mapper_v1_0 #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int C_NUM_BINS             = 1024,
  parameter int C_LO_FIRST             = 1,
  parameter int C_LO_LAST              = 400,
  parameter int C_HI_FIRST             = 623,
  parameter int C_HI_LAST              = 1022
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  output logic                                err_tlast
);

  localparam int BIN_W = $clog2(C_NUM_BINS);
  localparam logic [BIN_W-1:0] LO_FIRST = BIN_W'(C_LO_FIRST);
  localparam logic [BIN_W-1:0] LO_LAST  = BIN_W'(C_LO_LAST);
  localparam logic [BIN_W-1:0] HI_FIRST = BIN_W'(C_HI_FIRST);
  localparam logic [BIN_W-1:0] HI_LAST  = BIN_W'(C_HI_LAST);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(C_NUM_BINS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin;
  logic             load;
  logic             is_data;
  logic             at_last;
  logic             accept;
  logic [63:0]      mapped;

  // Sign is replicated down to bit 18, magnitude lands on bits 17:3; this is
  // the bit-exact inverse of the receiver's lane extraction.
  function automatic logic [31:0] lane(input logic [15:0] x);
    return {{14{x[15]}}, x[14:0], 3'b000};
  endfunction

  assign load     = ~m00_axis_tvalid | m00_axis_tready;
  assign is_data  = ((bin >= LO_FIRST) && (bin <= LO_LAST)) ||
                    ((bin >= HI_FIRST) && (bin <= HI_LAST));
  assign at_last  = (bin == LAST_BIN);
  assign mapped   = {lane(s00_axis_tdata[31:16]), lane(s00_axis_tdata[15:0])};

  // Payload is only pulled on data bins while the output register can take it.
  assign s00_axis_tready = (state == RUN) && is_data && load;
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};

  // Bin sequencer and one-beat output register.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state           <= IDLE;
      bin             <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Bin 0 (DC) is only emitted once payload for the symbol is pending.
          if (s00_axis_tvalid && load) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            bin             <= BIN_W'(1);
            state           <= RUN;
          end else if (load) begin
            m00_axis_tvalid <= 1'b0;
          end
        end
        RUN: begin
          if (load) begin
            if (is_data && !s00_axis_tvalid) begin
              // Underrun: let the register drain, bin position holds.
              m00_axis_tvalid <= 1'b0;
            end else begin
              m00_axis_tvalid <= 1'b1;
              m00_axis_tdata  <= is_data ? mapped : '0;
              m00_axis_tlast  <= at_last;
              if (at_last) begin
                bin   <= '0;
                state <= IDLE;
              end else begin
                bin <= bin + BIN_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flag for input tlast not matching the last payload bin.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      err_tlast <= 1'b0;
    end else if (accept && (s00_axis_tlast != (bin == HI_LAST))) begin
      err_tlast <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mapper_v1_0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mapper_v1_0
//  Description : Directed self-checking bench for mapper_v1_0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mapper_v1_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast, err_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb;

  int total = 0;
  int bad   = 0;
  logic        err_exp;
  logic [31:0] samp [0:799];
  logic [63:0] got  [0:1023];

  mapper_v1_0 dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .err_tlast       (err_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [15:0] x);
    return {{14{x[15]}}, x[14:0], 3'b000};
  endfunction

  function automatic logic [63:0] exp_beat(input int b);
    logic [31:0] s;
    if (b >= 1 && b <= 400)         s = samp[b - 1];
    else if (b >= 623 && b <= 1022) s = samp[b - 223];
    else return 64'h0;
    return {lane(s[31:16]), lane(s[15:0])};
  endfunction

  // Drives one symbol of 800 samples and checks all 1024 output beats.
  task automatic run_symbol(input int rnd, input int gap_idx, input int tlast_idx,
                            input int exp_gaps);
    int sent = 0, beats = 0, cyc = 0, gap_left = 5, gaps = 0;
    logic hold = 1'b0, held_l = 1'b0, err_set;
    logic [63:0] held_d = '0;
    while (beats < 1024 && cyc < 8000) begin
      cyc++;
      m_tready = (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent < 800 && !(sent == gap_idx && gap_left > 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = samp[sent];
        s_tlast  = (sent == tlast_idx);
      end else begin
        s_tvalid = 1'b0;
        if (sent == gap_idx && gap_left > 0) gap_left--;
      end
      #1;
      if (hold) begin
        chk("stall_valid", {63'd0, m_tvalid}, 64'd1);
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", {63'd0, m_tlast}, {63'd0, held_l});
      end
      if (m_tvalid && m_tready) begin
        chk($sformatf("beat%0d", beats), m_tdata, exp_beat(beats));
        chk($sformatf("last%0d", beats), {63'd0, m_tlast}, {63'd0, beats == 1023});
        got[beats] = m_tdata;
        beats++;
      end else if (!m_tvalid && beats > 0) begin
        gaps++;
      end
      hold   = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
      err_set = 1'b0;
      if (s_tvalid && s_tready) begin
        if ((sent == 799) != (sent == tlast_idx)) err_set = 1'b1;
        sent++;
      end
      @(posedge clk); #1;
      if (err_set) err_exp = 1'b1;
      chk("err_tlast", {63'd0, err_tlast}, {63'd0, err_exp});
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("beat_count", 64'(beats), 64'd1024);
    chk("sample_count", 64'(sent), 64'd800);
    if (exp_gaps >= 0) chk("bubbles", 64'(gaps), 64'(exp_gaps));
  endtask

  initial begin
    int beats, cyc, sent;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
    err_exp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    #1;
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_err", {63'd0, err_tlast}, 64'd0);
    chk("tstrb", {56'd0, m_tstrb}, 64'hFF);
    s_tvalid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Continuous symbol, I = Q = k
    for (int k = 0; k < 800; k++) samp[k] = {k[15:0], k[15:0]};
    run_symbol(0, -1, 799, 0);
    chk("c_bin0", got[0], 64'h0);
    chk("c_bin1", got[1], 64'h0);
    chk("c_bin400", got[400], 64'h00000C78_00000C78);
    chk("c_bin401", got[401], 64'h0);
    chk("c_bin622", got[622], 64'h0);
    chk("c_bin623", got[623], 64'h00000C80_00000C80);
    chk("c_bin1022", got[1022], 64'h000018F8_000018F8);
    chk("c_bin1023", got[1023], 64'h0);

    // Sign mapping on bin 1
    samp[0] = {16'h8001, 16'h7FFF};
    run_symbol(0, -1, 799, 0);
    chk("sign_bin1", got[1], 64'hFFFC0008_0003FFF8);

    // Random backpressure, three symbols with varied data
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 800; k++) samp[k] = $urandom();
      run_symbol(1, -1, 799, -1);
    end

    // Input underrun at bin 200
    for (int k = 0; k < 800; k++) samp[k] = {k[15:0], k[15:0]};
    run_symbol(0, 199, 799, 5);
    chk("u_bin199", got[199], 64'h00000630_00000630);
    chk("u_bin200", got[200], 64'h00000638_00000638);

    // Tlast on the 799th sample
    run_symbol(0, -1, 798, 0);
    chk("err_held", {63'd0, err_tlast}, 64'd1);

    // Reset in the middle of a symbol, near bin 500
    beats = 0; cyc = 0; sent = 0;
    while (beats < 500 && cyc < 2000) begin
      cyc++;
      m_tready = 1'b1;
      s_tvalid = 1'b1;
      s_tdata  = samp[sent];
      s_tlast  = 1'b0;
      #1;
      if (m_tvalid) beats++;
      if (s_tvalid && s_tready) sent++;
      @(posedge clk); #1;
    end
    chk("pre_rst_beats", 64'(beats), 64'd500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("mid_rst_tdata", m_tdata, 64'd0);
    chk("mid_rst_tlast", {63'd0, m_tlast}, 64'd0);
    chk("mid_rst_tready", {63'd0, s_tready}, 64'd0);
    chk("mid_rst_err", {63'd0, err_tlast}, 64'd0);
    s_tvalid = 1'b0;
    err_exp  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    samp[0] = {16'h0010, 16'hFFFF};
    run_symbol(0, -1, 799, 0);
    chk("post_rst_bin0", got[0], 64'h0);
    chk("post_rst_bin1", got[1], 64'h00000080_FFFFFFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
